// File: rtl/d_ff_pkg.sv
// Shared constants and helpers for the d_ff_pipe slice.
// Default geometry and occupancy counter width.
package d_ff_pkg;

    localparam int D_FF_WIDTH_DEF = 8;
    localparam int D_FF_DEPTH_DEF = 4;

    // Bits needed to count 0..depth valid entries.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/d_ff_if.sv
// Signal bundle for driving and observing a d_ff_pipe.
// Carries stall, flush, valid qualifiers and occupancy.
interface d_ff_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic clk
);

    logic                         rst;
    logic                         en;
    logic                         flush;
    logic                         in_valid;
    logic [WIDTH-1:0]             d;
    logic [WIDTH-1:0]             q;
    logic                         out_valid;
    logic [$clog2(DEPTH+1)-1:0]   occupancy;

    modport dut (
        input  clk, rst, en, flush, in_valid, d,
        output q, out_valid, occupancy
    );

    modport tb (
        input  clk, q, out_valid, occupancy,
        output rst, en, flush, in_valid, d
    );

endinterface

// File: rtl/d_ff_stage.sv
// One pipeline stage: enabled data flop plus valid flop.
// Flush clears only the valid bit; data holds.
module d_ff_stage #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             vin,
    output logic [WIDTH-1:0] q,
    output logic             vout
);

    // Priority: reset, then flush (valid only), then shift, else hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= RST_VAL;
            vout <= 1'b0;
        end else if (flush) begin
            vout <= 1'b0;
        end else if (en) begin
            q    <= d;
            vout <= vin;
        end
    end

endmodule

// File: rtl/d_ff_pipe.sv
// DEPTH-stage WIDTH-bit delay pipeline with valid tracking,
// global stall, valid-only flush and a registered occupancy count.
module d_ff_pipe
    import d_ff_pkg::*;
#(
    parameter int               WIDTH   = D_FF_WIDTH_DEF,
    parameter int               DEPTH   = D_FF_DEPTH_DEF,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           d,
    output logic [WIDTH-1:0]           q,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OW = occ_w(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] din;
    logic [DEPTH-1:0][WIDTH-1:0] data;
    logic [DEPTH-1:0]            vin;
    logic [DEPTH-1:0]            valid;
    logic [OW:0]                 occ_sum;

    assign din[0] = d;
    assign vin[0] = in_valid;

    for (genvar i = 1; i < DEPTH; i++) begin : g_link
        assign din[i] = data[i-1];
        assign vin[i] = valid[i-1];
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        d_ff_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .flush (flush),
            .d     (din[i]),
            .vin   (vin[i]),
            .q     (data[i]),
            .vout  (valid[i])
        );
    end

    assign q         = data[DEPTH-1];
    assign out_valid = valid[DEPTH-1];

    // One extra bit so +in/-out never wraps before truncation.
    always_comb begin
        occ_sum = {1'b0, occupancy}
                + {{OW{1'b0}}, in_valid}
                - {{OW{1'b0}}, valid[DEPTH-1]};
    end

    // Occupancy follows the same priority as the stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (en) begin
            occupancy <= OW'(occ_sum);
        end
    end

endmodule

// File: tb/tb_d_ff_pipe.sv
// Scoreboard bench for d_ff_pipe at DEPTH=4 and DEPTH=1
// driven by identical stimulus.
module tb_d_ff_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    d_ff_if #(.WIDTH(8), .DEPTH(4)) bus (.clk(clk));

    logic [7:0] q1;
    logic       ov1;
    logic [0:0] occ1;

    d_ff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) dut (
        .clk       (clk),
        .rst       (bus.rst),
        .en        (bus.en),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .d         (bus.d),
        .q         (bus.q),
        .out_valid (bus.out_valid),
        .occupancy (bus.occupancy)
    );

    d_ff_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h00)) dut1 (
        .clk       (clk),
        .rst       (bus.rst),
        .en        (bus.en),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .d         (bus.d),
        .q         (q1),
        .out_valid (ov1),
        .occupancy (occ1)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
    } ent_t;

    typedef struct {
        logic [7:0] q4;
        logic       v4;
        logic [2:0] o4;
        logic [7:0] q1;
        logic       v1;
        logic       o1;
    } exp_t;

    ent_t pipe[4];
    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference: four slots, slot 0 newest, slot 3 visible at q.
    task automatic model(input logic r, e, f, iv, input logic [7:0] dd);
        exp_t x;
        int   cnt;
        if (r) begin
            for (int i = 0; i < 4; i++) pipe[i] = '{1'b0, 8'h00};
        end else if (f) begin
            for (int i = 0; i < 4; i++) pipe[i].v = 1'b0;
        end else if (e) begin
            for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = '{iv, dd};
        end
        cnt = 0;
        for (int i = 0; i < 4; i++) cnt += int'(pipe[i].v);
        x.q4 = pipe[3].d;
        x.v4 = pipe[3].v;
        x.o4 = 3'(cnt);
        x.q1 = pipe[0].d;
        x.v1 = pipe[0].v;
        x.o1 = pipe[0].v;
        exp_q.push_back(x);
    endtask

    // Inputs change at negedge; model advances at posedge.
    task automatic step(input logic r, e, f, iv, input logic [7:0] dd);
        bus.rst      = r;
        bus.en       = e;
        bus.flush    = f;
        bus.in_valid = iv;
        bus.d        = dd;
        @(posedge clk);
        model(r, e, f, iv, dd);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Monitor: one observation per cycle, away from the clock edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("q4",   bus.q,                   e.q4);
            chk("ov4",  {7'd0, bus.out_valid},   {7'd0, e.v4});
            chk("occ4", {5'd0, bus.occupancy},   {5'd0, e.o4});
            chk("q1",   q1,                      e.q1);
            chk("ov1",  {7'd0, ov1},             {7'd0, e.v1});
            chk("occ1", {7'd0, occ1},            {7'd0, e.o1});
        end
    end

    initial begin
        // 1: reset held three edges with live input
        for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 8'hFF);
        // 2: stream 11..55 then drain
        for (int i = 1; i <= 5; i++) step(0, 1, 0, 1, 8'(i * 8'h11));
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'h00);
        // 3: fill A1..A4, stall three cycles, resume
        for (int i = 1; i <= 4; i++) step(0, 1, 0, 1, 8'(8'hA0 + i));
        for (int i = 0; i < 3; i++) step(0, 0, 0, i[0], 8'($urandom));
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'h00);
        // 4: alternating valid
        for (int i = 1; i <= 4; i++) step(0, 1, 0, ~i[0], 8'(i));
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'h00);
        // 5: flush a full pipe with a valid EE at the same edge
        for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 8'(8'hC0 + i));
        step(0, 1, 1, 1, 8'hEE);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 8'h00);
        // 6: reset mid-stream with three valid entries
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 8'(8'hB0 + i));
        step(1, 1, 0, 1, 8'h5A);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 8'(8'h70 + i));
        // random mix
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(63) == 0),
                 ($urandom_range(3) != 0),
                 ($urandom_range(15) == 0),
                 1'($urandom),
                 8'($urandom));
        end
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
